// File: rtl/md_cell_pkg.sv
// Neighbour-cell constants and the {Z,Y,X} cell id to lane slot decode.
// Shared by the force collector return path.
package md_cell_pkg;

  localparam int CELL_ID_WIDTH      = 3;
  localparam int FULL_CELL_ID_WIDTH = 3 * CELL_ID_WIDTH;
  localparam int NUM_NEIGHBOR_CELLS = 13;
  localparam int NUM_SLOTS          = NUM_NEIGHBOR_CELLS + 1;

  localparam logic [CELL_ID_WIDTH-1:0] CELL_1 = 3'b001;
  localparam logic [CELL_ID_WIDTH-1:0] CELL_2 = 3'b010;
  localparam logic [CELL_ID_WIDTH-1:0] CELL_3 = 3'b011;

  typedef struct packed {
    logic       legal;
    logic [3:0] slot;
  } slot_t;

  function automatic slot_t cell_id_to_slot(
    input logic [FULL_CELL_ID_WIDTH-1:0] full_id
  );
    logic [CELL_ID_WIDTH-1:0] x, y, z;
    slot_t r;
    z = full_id[8:6];
    y = full_id[5:3];
    x = full_id[2:0];
    r.legal = 1'b1;
    r.slot  = 4'd0;
    // Items are written in slot-name order: X, Y, Z
    case ({x, y, z})
      {CELL_2, CELL_2, CELL_2}: r.slot = 4'd0;
      {CELL_2, CELL_2, CELL_3}: r.slot = 4'd1;
      {CELL_2, CELL_3, CELL_1}: r.slot = 4'd2;
      {CELL_2, CELL_3, CELL_2}: r.slot = 4'd3;
      {CELL_2, CELL_3, CELL_3}: r.slot = 4'd4;
      {CELL_3, CELL_1, CELL_1}: r.slot = 4'd5;
      {CELL_3, CELL_1, CELL_2}: r.slot = 4'd6;
      {CELL_3, CELL_1, CELL_3}: r.slot = 4'd7;
      {CELL_3, CELL_2, CELL_1}: r.slot = 4'd8;
      {CELL_3, CELL_2, CELL_2}: r.slot = 4'd9;
      {CELL_3, CELL_2, CELL_3}: r.slot = 4'd10;
      {CELL_3, CELL_3, CELL_1}: r.slot = 4'd11;
      {CELL_3, CELL_3, CELL_2}: r.slot = 4'd12;
      {CELL_3, CELL_3, CELL_3}: r.slot = 4'd13;
      default:                  r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/force_data_collector_if.sv
// Input stream plus 14 per-cell output lanes of the force collector.
// master drives results in and takes lanes out; slave is the collector.
interface force_data_collector_if #(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7
);
  import md_cell_pkg::*;

  logic                                      in_valid;
  logic                                      in_ready;
  logic [FULL_CELL_ID_WIDTH-1:0]             in_cell_id;
  logic [PARTICLE_ID_WIDTH-1:0]              in_particle_id;
  logic [3*DATA_WIDTH-1:0]                   in_force;
  logic [NUM_SLOTS-1:0]                      out_valid;
  logic [NUM_SLOTS-1:0]                      out_ready;
  logic [NUM_SLOTS*PARTICLE_ID_WIDTH-1:0]    out_particle_id;
  logic [NUM_SLOTS*3*DATA_WIDTH-1:0]         out_force;

  modport master (
    output in_valid, in_cell_id, in_particle_id, in_force, out_ready,
    input  in_ready, out_valid, out_particle_id, out_force
  );

  modport slave (
    input  in_valid, in_cell_id, in_particle_id, in_force, out_ready,
    output in_ready, out_valid, out_particle_id, out_force
  );

endinterface

// File: rtl/force_lane_buffer.sv
// One-entry valid/ready holding register for a single cell lane.
// A load wins over a drain on the same edge, so a busy lane never bubbles.
module force_lane_buffer #(
  parameter int W = 103
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         ready,
  input  logic [W-1:0] din,
  output logic         valid,
  output logic [W-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/force_data_collector.sv
// Routes tagged partial forces to 14 per-cell lanes with per-lane backpressure.
// FORCE_COLLECTOR_DROP_CNT_EN enables the saturating illegal-id drop counter.
module force_data_collector
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH        = 32,
  parameter int PARTICLE_ID_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  force_data_collector_if.slave  bus,
  output logic                   all_idle,
  output logic [15:0]            drop_count
);

  localparam int FW = 3 * DATA_WIDTH;
  localparam int PW = PARTICLE_ID_WIDTH + FW;

  logic                          valid_a;
  logic [FULL_CELL_ID_WIDTH-1:0] cell_a;
  logic [PW-1:0]                 pay_a;
  slot_t                         dec_a;
  logic                          lane_free;
  logic                          drain_a;
  logic                          in_ready;
  logic                          accept;
  logic [NUM_SLOTS-1:0]          valid_b;
  logic [NUM_SLOTS-1:0]          load_b;
  logic [PW-1:0]                 pay_b [NUM_SLOTS];

  assign dec_a = cell_id_to_slot(cell_a);

  always_comb begin
    lane_free = 1'b0;
    load_b    = '0;
    if (dec_a.legal) begin
      lane_free = ~valid_b[dec_a.slot] | bus.out_ready[dec_a.slot];
    end
    if (valid_a && dec_a.legal && lane_free) begin
      load_b = NUM_SLOTS'(1) << dec_a.slot;
    end
  end

  // Illegal ids always leave stage A, so they never block the input
  assign drain_a      = valid_a & (~dec_a.legal | lane_free);
  assign in_ready     = ~valid_a | drain_a;
  assign bus.in_ready = in_ready;
  assign accept       = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_a <= 1'b0;
      cell_a  <= '0;
      pay_a   <= '0;
    end else if (accept) begin
      valid_a <= 1'b1;
      cell_a  <= bus.in_cell_id;
      pay_a   <= {bus.in_particle_id, bus.in_force};
    end else if (drain_a) begin
      valid_a <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_lane
    force_lane_buffer #(.W(PW)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_b[k]),
      .ready (bus.out_ready[k]),
      .din   (pay_a),
      .valid (valid_b[k]),
      .dout  (pay_b[k])
    );
    assign bus.out_particle_id[k*PARTICLE_ID_WIDTH +: PARTICLE_ID_WIDTH] =
      pay_b[k][PW-1 -: PARTICLE_ID_WIDTH];
    assign bus.out_force[k*FW +: FW] = pay_b[k][FW-1:0];
  end

  assign bus.out_valid = valid_b;
  assign all_idle      = ~valid_a & ~|valid_b;

`ifdef FORCE_COLLECTOR_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (valid_a && !dec_a.legal && drop_count != 16'hFFFF) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: doc/force_data_collector.md
Name: force_data_collector

Overview:
- Return path of the neighbour-cell datapath. Force evaluation emits neighbour-particle partial forces tagged with the local cell id (Z,Y,X; 3 bits each).
- This block decodes the tag back to one of 14 cell slots (home plus 13 neighbours) and forwards each result to that cell's force cache port.
- Each of the 14 output lanes has its own valid/ready handshake and one-entry holding buffer, so backpressure is per cell.

Parameters:
- DATA_WIDTH, 32, width of one force component.
- CELL_ID_WIDTH, 3, width of one axis cell id.
- FULL_CELL_ID_WIDTH, 3*CELL_ID_WIDTH, Z,Y,X concatenated cell id.
- PARTICLE_ID_WIDTH, 7, particle index within a cell.
- NUM_NEIGHBOR_CELLS, 13, neighbour cells; there are NUM_NEIGHBOR_CELLS+1 lanes.
- CELL_1 / CELL_2 / CELL_3, 3'b001 / 3'b010 / 3'b011, axis cell codes.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  force result present.
- in_ready  out  1  result accepted when in_valid && in_ready.
- in_cell_id  in  FULL_CELL_ID_WIDTH  {Z,Y,X}; X in the LSBs.
- in_particle_id  in  PARTICLE_ID_WIDTH  target particle.
- in_force  in  3*DATA_WIDTH  {Fz,Fy,Fx}; Fx in the LSBs.
- out_valid  out  NUM_NEIGHBOR_CELLS+1  per-lane valid; lane index = cell slot.
- out_ready  in  NUM_NEIGHBOR_CELLS+1  per-lane ready from the force caches.
- out_particle_id  out  (NUM_NEIGHBOR_CELLS+1)*PARTICLE_ID_WIDTH  per-lane particle id.
- out_force  out  (NUM_NEIGHBOR_CELLS+1)*3*DATA_WIDTH  per-lane force.
- all_idle  out  1  no result held anywhere in the block.
- drop_count  out  16  count of results with an illegal cell id.

Behaviour:
- Slot map, name digits X,Y,Z:
  - 222=0, 223=1, 231=2, 232=3, 233=4, 311=5, 312=6.
  - 313=7, 321=8, 322=9, 323=10, 331=11, 332=12, 333=13.
  - Example: in_cell_id {Z=1,Y=3,X=3} maps to slot 11.
  - Any other code is illegal.
- Stage A: one input register (valid_a, cell id, pid, force).
  - in_ready = ~valid_a || drain_a.
  - drain_a = illegal id || ~valid_b[k] || out_ready[k], where k is the decoded slot of stage A.
  - in_ready never depends on in_valid or the current input payload.
- Stage B: 14 holding registers, one per lane.
  - out_valid[k] = valid_b[k]. Outputs come straight from the registers; no combinational path from in_* to out_*.
  - Lane k clears when out_ready[k] is high and no load occurs that cycle.
  - Drain and load on the same edge: the new payload replaces the old and out_valid[k] stays 1 (no bubble).
- Latency: accepted at edge N, visible on out_* after edge N+1. Throughput is 1 result per cycle with no stalls.
- Illegal id: the result is discarded from stage A in one cycle and drop_count increments, saturating at 16'hFFFF.
- Ordering: preserved per lane; no ordering guarantee across lanes.
- Stall: out_* stay stable while out_valid[k] is high and out_ready[k] is low.
- all_idle = ~valid_a && ~|valid_b. It is registered-state only.
- Reset:
  - All valids 0, data registers 0, drop_count 0.
  - in_ready = 1 and all_idle = 1 after reset.
  - Reset asserted mid-operation discards all held results with no output handshake.

Optional Feature:
- FORCE_COLLECTOR_DROP_CNT_EN.
- Defined: drop_count is implemented as above.
- Undefined: the counter logic is removed and drop_count is tied to 0. Illegal ids are still discarded silently.

Decomposition:
- Package md_cell_pkg holds:
  - CELL_1/2/3, CELL_ID_WIDTH, NUM_NEIGHBOR_CELLS.
  - The slot count constant.
  - A function cell_id_to_slot(full_id) returning {legal, slot[3:0]}.
- One sub-module, force_lane_buffer: a one-entry valid/ready holding register with load/drain, instantiated 14 times.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 → out_valid=0, drop_count=0; in_ready=1 and all_idle=1 after release.
- Decode: cell {Z=1,Y=3,X=3}, pid 5, force (Fx=1,Fy=2,Fz=3) → after edge N+1, out_valid=14'h0800 with lane-11 payload pid 5 and (1,2,3).
- Backpressure: out_ready[0]=0, send 3 results to 222 → after 2 accepts in_ready=0. Raise out_ready[0] → pids delivered 1,2,3 in order, no loss or duplicate.
- Illegal id 9'b000_010_010 → no out_valid, in_ready stays 1. drop_count=1 with the macro defined, 0 without.
- Streaming: 14 back-to-back results, one per slot, all out_ready=1 → one out_valid pulse per lane on consecutive cycles, in_ready constantly 1, all_idle=1 two edges after the last accept.
- Drain/load collision: lane 3 holding pid 7, out_ready[3]=1 on the same edge that pid 8 for 232 loads → out_valid[3] stays 1, payload switches to pid 8.
